// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: oversample ticks with a dvsr_int+1+frac/2^FRAC_BITS
// average period, plus bit-boundary and bit-centre pulses derived from the oversample index.
module baud_gen_frac #(
    parameter int BITS      = 16,
    parameter int FRAC_BITS = 4,
    parameter int OSR       = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [BITS-1:0]         dvsr_int,
    input  logic [FRAC_BITS-1:0]    dvsr_frac,
    input  logic                    load,
    input  logic                    sync_restart,
    output logic                    sample_tick,
    output logic                    bit_tick,
    output logic                    mid_tick,
    output logic [$clog2(OSR)-1:0]  os_phase
);

    localparam int PW = $clog2(OSR);
    localparam logic [PW-1:0] OS_LAST    = PW'(OSR - 1);
    localparam logic [PW-1:0] OS_MID_PRE = PW'(OSR / 2 - 1);
    localparam logic [PW-1:0] OS_ONE     = PW'(1);
    localparam logic [BITS:0] CNT_ONE    = (BITS + 1)'(1);

    if (OSR < 2 || (OSR % 2) != 0) begin : g_bad_osr
        $error("baud_gen_frac: OSR must be even and at least 2");
    end

    logic [BITS:0]          cnt_q, cnt_d;
    logic [FRAC_BITS-1:0]   acc_q, acc_d;
    logic                   ext_q, ext_d;
    logic [PW-1:0]          os_cnt_q, os_cnt_d;
    logic [BITS-1:0]        act_int_q, act_int_d;
    logic [FRAC_BITS-1:0]   act_frac_q, act_frac_d;
    logic [BITS-1:0]        pend_int_q, pend_int_d;
    logic [FRAC_BITS-1:0]   pend_frac_q, pend_frac_d;
    logic                   pend_valid_q, pend_valid_d;
    logic                   sample_tick_q, sample_tick_d;
    logic                   bit_tick_q, bit_tick_d;
    logic                   mid_tick_q, mid_tick_d;

    logic [BITS:0]          limit;
    logic                   boundary;
    logic [FRAC_BITS:0]     acc_sum;
    logic                   apply;

    always_comb begin
        limit    = {1'b0, act_int_q} + {{BITS{1'b0}}, ext_q};
        // >= rather than == so a smaller divisor applied while frozen cannot strand cnt above limit
        boundary = (cnt_q >= limit);
        acc_sum  = {1'b0, acc_q} + {1'b0, act_frac_q};
        apply    = 1'b0;

        cnt_d         = cnt_q;
        acc_d         = acc_q;
        ext_d         = ext_q;
        os_cnt_d      = os_cnt_q;
        act_int_d     = act_int_q;
        act_frac_d    = act_frac_q;
        pend_int_d    = pend_int_q;
        pend_frac_d   = pend_frac_q;
        pend_valid_d  = pend_valid_q;
        sample_tick_d = 1'b0;
        bit_tick_d    = 1'b0;
        mid_tick_d    = 1'b0;

        if (sync_restart) begin
            cnt_d        = '0;
            acc_d        = '0;
            ext_d        = 1'b0;
            os_cnt_d     = '0;
            pend_valid_d = 1'b0;
            if (load) begin
                act_int_d  = dvsr_int;
                act_frac_d = dvsr_frac;
            end else if (pend_valid_q) begin
                act_int_d  = pend_int_q;
                act_frac_d = pend_frac_q;
            end
        end else begin
            if (enable) begin
                if (boundary) begin
                    cnt_d         = '0;
                    os_cnt_d      = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_ONE;
                    sample_tick_d = 1'b1;
                    bit_tick_d    = (os_cnt_q == OS_LAST);
                    mid_tick_d    = (os_cnt_q == OS_MID_PRE);
                    if (pend_valid_q) begin
                        apply = 1'b1;
                    end else begin
                        acc_d = acc_sum[FRAC_BITS-1:0];
                        ext_d = acc_sum[FRAC_BITS];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                apply = pend_valid_q;
            end

            if (apply) begin
                act_int_d    = pend_int_q;
                act_frac_d   = pend_frac_q;
                acc_d        = '0;
                ext_d        = 1'b0;
                pend_valid_d = 1'b0;
            end

            // A load in the same cycle as an apply becomes the next pending value
            if (load) begin
                pend_int_d   = dvsr_int;
                pend_frac_d  = dvsr_frac;
                pend_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            acc_q         <= '0;
            ext_q         <= 1'b0;
            os_cnt_q      <= '0;
            act_int_q     <= dvsr_int;
            act_frac_q    <= dvsr_frac;
            pend_int_q    <= '0;
            pend_frac_q   <= '0;
            pend_valid_q  <= 1'b0;
            sample_tick_q <= 1'b0;
            bit_tick_q    <= 1'b0;
            mid_tick_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            ext_q         <= ext_d;
            os_cnt_q      <= os_cnt_d;
            act_int_q     <= act_int_d;
            act_frac_q    <= act_frac_d;
            pend_int_q    <= pend_int_d;
            pend_frac_q   <= pend_frac_d;
            pend_valid_q  <= pend_valid_d;
            sample_tick_q <= sample_tick_d;
            bit_tick_q    <= bit_tick_d;
            mid_tick_q    <= mid_tick_d;
        end
    end

    assign sample_tick = sample_tick_q;
    assign bit_tick    = bit_tick_q;
    assign mid_tick    = mid_tick_q;
    assign os_phase    = os_cnt_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: directed scenarios plus random traffic, each cycle compared
// against a period-level reference model.
module tb_baud_gen_frac;

    localparam int BITS      = 8;
    localparam int FRAC_BITS = 4;
    localparam int OSR       = 4;
    localparam int PW        = $clog2(OSR);
    localparam int W         = 3 + PW;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 enable = 1'b0;
    logic [BITS-1:0]      dvsr_int = '0;
    logic [FRAC_BITS-1:0] dvsr_frac = '0;
    logic                 load = 1'b0;
    logic                 sync_restart = 1'b0;
    logic                 sample_tick;
    logic                 bit_tick;
    logic                 mid_tick;
    logic [PW-1:0]        os_phase;

    int checks = 0;
    int errors = 0;

    // Reference model: divisor, period index since last divisor change, cycles into
    // current period, sample ticks since restart, pending divisor.
    int m_int, m_frac, m_k, m_el, m_n, m_pint, m_pfrac;
    bit m_pv;
    logic [W-1:0] exp_q[$];

    baud_gen_frac #(.BITS(BITS), .FRAC_BITS(FRAC_BITS), .OSR(OSR)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .dvsr_int(dvsr_int), .dvsr_frac(dvsr_frac),
        .load(load), .sync_restart(sync_restart),
        .sample_tick(sample_tick), .bit_tick(bit_tick), .mid_tick(mid_tick),
        .os_phase(os_phase)
    );

    always #5 clk = ~clk;

    // Extra cycle owed by period k: growth of floor(k*frac/2^F) across that boundary.
    function automatic int extra(input int k, input int f);
        if (k == 0) return 0;
        return ((k * f) >> FRAC_BITS) - (((k - 1) * f) >> FRAC_BITS);
    endfunction

    task automatic model_step();
        bit s, b, m, applied;
        int plen;
        s = 0; b = 0; m = 0; applied = 0;
        if (reset) begin
            m_int = int'(dvsr_int); m_frac = int'(dvsr_frac);
            m_k = 0; m_el = 0; m_n = 0; m_pv = 0;
        end else if (sync_restart) begin
            if (load) begin
                m_int = int'(dvsr_int); m_frac = int'(dvsr_frac);
            end else if (m_pv) begin
                m_int = m_pint; m_frac = m_pfrac;
            end
            m_pv = 0; m_k = 0; m_el = 0; m_n = 0;
        end else begin
            if (enable) begin
                plen = m_int + 1 + extra(m_k, m_frac);
                if (m_el + 1 >= plen) begin
                    s = 1;
                    b = (m_n % OSR) == OSR - 1;
                    m = (m_n % OSR) == OSR / 2 - 1;
                    m_n = m_n + 1;
                    m_el = 0;
                    if (m_pv) begin
                        m_int = m_pint; m_frac = m_pfrac; m_k = 0; applied = 1;
                    end else begin
                        m_k = m_k + 1;
                    end
                end else begin
                    m_el = m_el + 1;
                end
            end else if (m_pv) begin
                m_int = m_pint; m_frac = m_pfrac; m_k = 0; applied = 1;
            end
            if (load) begin
                m_pint = int'(dvsr_int); m_pfrac = int'(dvsr_frac); m_pv = 1;
            end else if (applied) begin
                m_pv = 0;
            end
        end
        exp_q.push_back({m, b, s, PW'(m_n % OSR)});
    endtask

    // One clock: model consumes the inputs the DUT is about to sample, then compare.
    task automatic cycle(input string tag);
        logic [W-1:0] exp_v, got_v;
        model_step();
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        got_v = {mid_tick, bit_tick, sample_tick, os_phase};
        checks++;
        assert (got_v === exp_v) else begin
            errors++;
            $error("FAIL %s: {mid,bit,sample,phase} got %b expected %b", tag, got_v, exp_v);
        end
    endtask

    task automatic check(input string tag, input int got, input int exp_v);
        checks++;
        assert (got === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp_v);
        end
    endtask

    // sel: 0 sample_tick, 1 bit_tick, 2 mid_tick. Returns cycles until it is seen.
    task automatic wait_sig(input string tag, input int sel, output int n);
        bit hit;
        hit = 0; n = 0;
        while (!hit && n < 1000) begin
            cycle(tag);
            n++;
            hit = (sel == 0) ? sample_tick : (sel == 1) ? bit_tick : mid_tick;
        end
        if (!hit) begin
            checks++;
            errors++;
            $error("FAIL %s: timeout after %0d cycles", tag, n);
        end
    endtask

    task automatic do_reset(input int di, input int df);
        reset = 1'b1; enable = 1'b0; load = 1'b0; sync_restart = 1'b0;
        dvsr_int = BITS'(di); dvsr_frac = FRAC_BITS'(df);
        cycle("reset");
        reset = 1'b0; enable = 1'b1;
    endtask

    task automatic pulse_load(input int di, input int df, input bit with_sync);
        dvsr_int = BITS'(di); dvsr_frac = FRAC_BITS'(df);
        load = 1'b1; sync_restart = with_sync;
        cycle("load");
        load = 1'b0; sync_restart = 1'b0;
    endtask

    initial begin
        int n, sum, seen;

        // Reset state
        do_reset(3, 0);
        check("reset_sample", int'(sample_tick), 0);
        check("reset_phase", int'(os_phase), 0);

        // Integer divisor: mid 8 cycles in, bit every 16, mid 8 after each bit
        wait_sig("mid_first", 2, n);  check("mid_first_gap", n, 8);
        wait_sig("bit_first", 1, n);  check("bit_first_gap", n, 8);
        wait_sig("mid_again", 2, n);  check("mid_after_bit", n, 8);
        wait_sig("bit_again", 1, n);  check("bit_after_mid", n, 8);
        for (int i = 0; i < 4; i++) begin
            wait_sig("tick_spacing", 0, n);
            check("tick_spacing", n, 4);
            check("phase_seq", int'(os_phase), (i + 1) % OSR);
        end

        // Fractional divisor 3 + 8/16
        do_reset(3, 8);
        wait_sig("frac_first", 0, n); check("frac_first", n, 4);
        sum = 0;
        for (int p = 1; p <= 32; p++) begin
            wait_sig("frac_period", 0, n);
            check("frac_period", n, (p % 2 == 0) ? 5 : 4);
            sum += n;
        end
        check("frac_total_32", sum, 144);

        // Enable gap mid-period
        do_reset(3, 0);
        wait_sig("gap_pre", 0, n);
        cycle("gap_run"); cycle("gap_run");
        enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            cycle("gap_off");
            seen += int'(sample_tick | bit_tick | mid_tick);
        end
        check("gap_no_ticks", seen, 0);
        enable = 1'b1;
        wait_sig("gap_resume", 0, n); check("gap_remaining", n, 2);

        // Load mid-period: current period unchanged, next uses new divisor
        cycle("load_pre");
        pulse_load(7, 0, 1'b0);
        wait_sig("load_cur", 0, n); check("load_cur_period", n + 2, 4);
        wait_sig("load_next", 0, n); check("load_next_period", n, 8);

        // sync_restart on a boundary cycle
        for (int i = 0; i < 7; i++) cycle("sync_pre");
        sync_restart = 1'b1;
        cycle("sync_boundary");
        sync_restart = 1'b0;
        check("sync_no_tick", int'(sample_tick), 0);
        check("sync_phase", int'(os_phase), 0);
        wait_sig("sync_next", 0, n); check("sync_next_period", n, 8);
        check("sync_phase_after", int'(os_phase), 1);

        // load together with sync_restart takes effect immediately
        cycle("ls_pre"); cycle("ls_pre");
        pulse_load(1, 0, 1'b1);
        wait_sig("ls_first", 0, n); check("ls_first_period", n, 2);
        wait_sig("ls_second", 0, n); check("ls_second_period", n, 2);

        // Reset with a load pending: pending discarded, divisor sampled in reset used
        pulse_load(2, 0, 1'b0);
        do_reset(5, 0);
        check("rst_mid_sample", int'(sample_tick), 0);
        check("rst_mid_bit", int'(bit_tick), 0);
        check("rst_mid_mid", int'(mid_tick), 0);
        check("rst_mid_phase", int'(os_phase), 0);
        wait_sig("rst_first", 0, n); check("rst_first_period", n, 6);
        wait_sig("rst_second", 0, n); check("rst_second_period", n, 6);

        // Zero divisor: sample_tick continuously high
        do_reset(0, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            cycle("zero_div");
            seen += int'(sample_tick);
        end
        check("zero_div_ticks", seen, 8);

        // Maximum divisor with fractional carry: cnt must reach 2^BITS
        do_reset(255, 8);
        wait_sig("max_p0", 0, n); check("max_p0", n, 256);
        wait_sig("max_p1", 0, n); check("max_p1", n, 256);
        wait_sig("max_p2", 0, n); check("max_p2", n, 257);

        // Load while disabled applies on the following cycle
        enable = 1'b0;
        pulse_load(3, 0, 1'b0);
        cycle("dis_apply");
        enable = 1'b1;
        wait_sig("dis_first", 0, n); check("dis_first_period", n, 4);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            reset        = ($urandom_range(0, 299) == 0);
            enable       = ($urandom_range(0, 7) != 0);
            load         = ($urandom_range(0, 15) == 0);
            sync_restart = ($urandom_range(0, 39) == 0);
            dvsr_int     = BITS'($urandom_range(0, 6));
            dvsr_frac    = FRAC_BITS'($urandom_range(0, 15));
            cycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
